// File: rtl/dice_datapath_pkg.sv
// Shared types and constants for the dice-game datapath: die/sum widths,
// die range and the sum values the controller branches on.
package dice_pkg;

    typedef logic [2:0] die_t;
    typedef logic [3:0] sum_t;

    localparam die_t DIE_MIN = 3'd1;
    localparam die_t DIE_MAX = 3'd6;

    localparam sum_t SUM_SEVEN    = 4'd7;
    localparam sum_t SUM_ELEVEN   = 4'd11;
    localparam sum_t SUM_CRAPS_2  = 4'd2;
    localparam sum_t SUM_CRAPS_3  = 4'd3;
    localparam sum_t SUM_CRAPS_12 = 4'd12;

    function automatic logic is_craps(input sum_t s);
        return (s == SUM_CRAPS_2) || (s == SUM_CRAPS_3) || (s == SUM_CRAPS_12);
    endfunction

endpackage

// File: rtl/dice_datapath_if.sv
// Controller <-> datapath bundle. Commands and levels are plain per-cycle
// signals sampled on the rising clock edge; there is no valid/ready pairing.
interface dice_datapath_if #(
    parameter int CNT_W = 8
);
    logic                roll_btn;
    logic                inc;
    logic                ld;
    logic                win;
    logic                lose;
    logic                sync_x;
    logic                eq6;
    logic                eq7;
    logic                eq11;
    logic                eq;
    dice_pkg::die_t      die_a;
    dice_pkg::die_t      die_b;
    dice_pkg::sum_t      sum;
    dice_pkg::sum_t      point;
    logic [CNT_W-1:0]    win_cnt;
    logic [CNT_W-1:0]    lose_cnt;

    modport master (
        output roll_btn, inc, ld, win, lose,
        input  sync_x, eq6, eq7, eq11, eq, die_a, die_b, sum, point,
               win_cnt, lose_cnt
    );

    modport slave (
        input  roll_btn, inc, ld, win, lose,
        output sync_x, eq6, eq7, eq11, eq, die_a, die_b, sum, point,
               win_cnt, lose_cnt
    );

endinterface

// File: rtl/dice_datapath_die_counter.sv
// One die: counts DIE_MIN..DIE_MAX while enabled; carry flags the wrap so a
// second die can be chained to it.
module die_counter
    import dice_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output die_t o_value,
    output logic o_carry
);

    die_t r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= DIE_MIN;
        end else if (i_en) begin
            r_value <= (r_value == DIE_MAX) ? DIE_MIN : r_value + 3'd1;
        end
    end

    assign o_value = r_value;
    assign o_carry = i_en && (r_value == DIE_MAX);

endmodule

// File: rtl/dice_datapath.sv
// Dice-game datapath: button synchronizer/debouncer, chained dice, point
// register, comparison flags for the controller and saturating win/lose tallies.
module dice_datapath
    import dice_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    dice_datapath_if.slave  bus
);

    localparam int               DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_END = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sync1;
    logic             r_btn_s;
    logic             r_sync_x;
    logic [DEB_W-1:0] r_deb_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= bus.roll_btn;
            r_btn_s <= r_sync1;
        end
    end

    // sync_x only follows btn_s after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_x  <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_btn_s == r_sync_x) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_END) begin
            r_sync_x  <= r_btn_s;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    die_t w_die_a;
    die_t w_die_b;
    logic w_carry_a;
    logic w_carry_b;
    sum_t w_sum;

    die_counter u_die_a (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (bus.inc),
        .o_value (w_die_a),
        .o_carry (w_carry_a)
    );

    die_counter u_die_b (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_carry_a),
        .o_value (w_die_b),
        .o_carry (w_carry_b)
    );

    assign w_sum = {1'b0, w_die_a} + {1'b0, w_die_b};

    // point captures the pre-edge sum, so ld together with inc keeps the old roll
    sum_t r_point;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_point <= '0;
        end else if (bus.ld) begin
            r_point <= w_sum;
        end
    end

    logic             r_win_d;
    logic             r_lose_d;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_lose_cnt;
    logic             w_win_rise;
    logic             w_lose_rise;

    assign w_win_rise  = bus.win  && !r_win_d;
    assign w_lose_rise = bus.lose && !r_lose_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_d    <= 1'b0;
            r_lose_d   <= 1'b0;
            r_win_cnt  <= '0;
            r_lose_cnt <= '0;
        end else begin
            r_win_d  <= bus.win;
            r_lose_d <= bus.lose;
            if (w_win_rise && (r_win_cnt != CNT_MAX)) begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
            end
            if (w_lose_rise && (r_lose_cnt != CNT_MAX)) begin
                r_lose_cnt <= r_lose_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.sync_x   = r_sync_x;
    assign bus.die_a    = w_die_a;
    assign bus.die_b    = w_die_b;
    assign bus.sum      = w_sum;
    assign bus.point    = r_point;
    assign bus.eq6      = is_craps(w_sum);
    assign bus.eq7      = (w_sum == SUM_SEVEN);
    assign bus.eq11     = (w_sum == SUM_ELEVEN);
    assign bus.eq       = (w_sum == r_point);
    assign bus.win_cnt  = r_win_cnt;
    assign bus.lose_cnt = r_lose_cnt;

endmodule

// File: tb/tb_dice_datapath.sv
// Bench for dice_datapath: directed test-plan steps plus a randomized run,
// all checked every cycle against a behavioural model of the game datapath.
module tb_dice_datapath;

    localparam int DEB   = 16;
    localparam int CW    = 2;
    localparam int SATV  = (1 << CW) - 1;

    logic clk;
    logic reset;

    dice_datapath_if #(.CNT_W(CW)) bus ();

    dice_datapath #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // model: the dice pair is a position 0..35 in the 36-roll cycle
    int   m_idx;
    int   m_point;
    int   m_win;
    int   m_lose;
    bit   m_win_prev;
    bit   m_lose_prev;
    bit   m_sync;
    bit   raw_q[$];

    function automatic int m_a();   return (m_idx % 6) + 1; endfunction
    function automatic int m_b();   return (m_idx / 6) + 1; endfunction
    function automatic int m_sum(); return m_a() + m_b();   endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_point = 0; m_win = 0; m_lose = 0;
        m_win_prev = 0; m_lose_prev = 0; m_sync = 0;
        raw_q.delete();
        for (int i = 0; i < DEB + 2; i++) raw_q.push_back(1'b0);
    endtask

    task automatic check_all();
        int s;
        s = m_sum();
        chk("die_a",    32'(bus.die_a),    m_a());
        chk("die_b",    32'(bus.die_b),    m_b());
        chk("sum",      32'(bus.sum),      s);
        chk("eq6",      32'(bus.eq6),      (s == 2 || s == 3 || s == 12) ? 1 : 0);
        chk("eq7",      32'(bus.eq7),      (s == 7) ? 1 : 0);
        chk("eq11",     32'(bus.eq11),     (s == 11) ? 1 : 0);
        chk("eq",       32'(bus.eq),       (s == m_point) ? 1 : 0);
        chk("point",    32'(bus.point),    m_point);
        chk("win_cnt",  32'(bus.win_cnt),  m_win);
        chk("lose_cnt", 32'(bus.lose_cnt), m_lose);
        chk("sync_x",   32'(bus.sync_x),   m_sync);
    endtask

    // one clock: capture inputs, apply edge rules to the model, compare
    task automatic cyc();
        bit inc_s, ld_s, win_s, lose_s, btn_s, flip;
        int n;
        inc_s = bus.inc; ld_s = bus.ld; win_s = bus.win; lose_s = bus.lose;
        btn_s = bus.roll_btn;
        @(posedge clk);
        if (ld_s) m_point = m_sum();
        if (inc_s) m_idx = (m_idx + 1) % 36;
        if (win_s && !m_win_prev && m_win < SATV) m_win++;
        if (lose_s && !m_lose_prev && m_lose < SATV) m_lose++;
        m_win_prev = win_s;
        m_lose_prev = lose_s;
        // flip once the button, two edges late, disagreed for DEB edges in a row
        n = raw_q.size();
        flip = 1'b1;
        for (int k = n - 1 - DEB; k <= n - 2; k++)
            if (raw_q[k] == m_sync) flip = 1'b0;
        if (flip) begin
            m_sync = !m_sync;
            for (int k = 0; k < n; k++) raw_q[k] = m_sync;
        end
        raw_q.push_back(btn_s);
        if (raw_q.size() > DEB + 4) void'(raw_q.pop_front());
        #1;
        check_all();
    endtask

    task automatic goto_dice(input int a, input int b);
        int target;
        target = (b - 1) * 6 + (a - 1);
        bus.inc = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (m_idx == target) break;
            cyc();
        end
        bus.inc = 1'b0;
        chk("goto_a", 32'(bus.die_a), a);
        chk("goto_b", 32'(bus.die_b), b);
    endtask

    initial begin
        reset = 1'b0;
        bus.roll_btn = 1'b0; bus.inc = 1'b0; bus.ld = 1'b0;
        bus.win = 1'b0; bus.lose = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
        cyc();
        chk("rst_die_a", 32'(bus.die_a), 1);
        chk("rst_die_b", 32'(bus.die_b), 1);
        chk("rst_sum",   32'(bus.sum),   2);
        chk("rst_eq6",   32'(bus.eq6),   1);
        chk("rst_eq",    32'(bus.eq),    0);
        chk("rst_point", 32'(bus.point), 0);
        chk("rst_sync",  32'(bus.sync_x), 0);
        chk("rst_win",   32'(bus.win_cnt), 0);

        // dice wrap
        bus.inc = 1'b1;
        repeat (35) cyc();
        chk("wrap66_a",   32'(bus.die_a), 6);
        chk("wrap66_b",   32'(bus.die_b), 6);
        chk("wrap66_sum", 32'(bus.sum),   12);
        chk("wrap66_eq6", 32'(bus.eq6),   1);
        cyc();
        chk("wrap11_a", 32'(bus.die_a), 1);
        chk("wrap11_b", 32'(bus.die_b), 1);
        bus.inc = 1'b0;
        goto_dice(6, 2);
        bus.inc = 1'b1;
        cyc();
        bus.inc = 1'b0;
        chk("carry_a",   32'(bus.die_a), 1);
        chk("carry_b",   32'(bus.die_b), 3);
        chk("carry_sum", 32'(bus.sum),   4);

        // debounce: short pulse is rejected, long hold passes after DEB+2 edges
        bus.roll_btn = 1'b1;
        repeat (DEB - 4) cyc();
        bus.roll_btn = 1'b0;
        for (int i = 0; i < DEB + 8; i++) begin
            cyc();
            chk("deb_short", 32'(bus.sync_x), 0);
        end
        bus.roll_btn = 1'b1;
        repeat (DEB + 1) cyc();
        chk("deb_early", 32'(bus.sync_x), 0);
        cyc();
        chk("deb_rise", 32'(bus.sync_x), 1);

        // point load and compare
        goto_dice(3, 5);
        bus.ld = 1'b1;
        cyc();
        bus.ld = 1'b0;
        chk("pt_val", 32'(bus.point), 8);
        chk("pt_eq",  32'(bus.eq),    1);
        bus.inc = 1'b1;
        cyc();
        bus.inc = 1'b0;
        chk("pt_sum9", 32'(bus.sum), 9);
        chk("pt_neq",  32'(bus.eq),  0);

        // ld and inc together
        goto_dice(2, 2);
        bus.ld = 1'b1; bus.inc = 1'b1;
        cyc();
        bus.ld = 1'b0; bus.inc = 1'b0;
        chk("ldinc_pt", 32'(bus.point), 4);
        chk("ldinc_a",  32'(bus.die_a), 3);
        chk("ldinc_b",  32'(bus.die_b), 2);

        // tallies
        bus.win = 1'b1;
        cyc();
        chk("win_first", 32'(bus.win_cnt), 1);
        repeat (4) cyc();
        bus.win = 1'b0;
        cyc();
        chk("win_level", 32'(bus.win_cnt), 1);
        bus.win = 1'b1; bus.lose = 1'b1;
        cyc();
        bus.win = 1'b0; bus.lose = 1'b0;
        cyc();
        chk("both_win",  32'(bus.win_cnt),  2);
        chk("both_lose", 32'(bus.lose_cnt), 1);
        for (int i = 0; i < 4; i++) begin
            bus.lose = 1'b1; cyc();
            bus.lose = 1'b0; cyc();
        end
        chk("lose_sat", 32'(bus.lose_cnt), 3);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            bus.inc  = ($urandom_range(1, 0) == 1);
            bus.ld   = ($urandom_range(3, 0) == 0);
            bus.win  = ($urandom_range(2, 0) == 0);
            bus.lose = ($urandom_range(2, 0) == 0);
            if ($urandom_range(11, 0) == 0) bus.roll_btn = !bus.roll_btn;
            cyc();
        end

        // reset mid-roll clears everything at once
        bus.inc = 1'b1; bus.win = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        bus.inc = 1'b0; bus.win = 1'b0; bus.ld = 1'b0; bus.lose = 1'b0;
        bus.roll_btn = 1'b0;
        #2;
        reset = 1'b1;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
